// File: rtl/axi_inf_write_burst_core.sv
// AXI4 write-address/response controller: splits one request into INCR bursts of at most
// MAX_BURST beats that never cross a 4KB page, with one burst outstanding at a time.
module axi_inf_write_burst_core #(
    parameter int IDSIZE    = 3,
    parameter int ID        = 0,
    parameter int LSIZE     = 8,
    parameter int ASIZE     = 32,
    parameter int TSIZE     = 16,
    parameter int DSIZE     = 256,
    parameter int MAX_BURST = 16
) (
    input  logic              axi_aclk,
    input  logic              axi_resetn,
    input  logic              write_req,
    input  logic [TSIZE-1:0]  req_len,
    input  logic [ASIZE-1:0]  req_addr,
    output logic              req_resp,
    output logic              req_done,
    output logic              req_err,
    output logic              pull_data_en,
    output logic [IDSIZE-1:0] axi_awid,
    output logic [ASIZE-1:0]  axi_awaddr,
    output logic [LSIZE-1:0]  axi_awlen,
    output logic [2:0]        axi_awsize,
    output logic [1:0]        axi_awburst,
    output logic              axi_awvalid,
    input  logic              axi_awready,
    output logic              axi_bready,
    input  logic [IDSIZE-1:0] axi_bid,
    input  logic [1:0]        axi_bresp,
    input  logic              axi_bvalid,
    output logic              axi_wlast,
    input  logic              axi_wvalid,
    input  logic              axi_wready
);
    localparam int BYTES = DSIZE / 8;
    localparam int ASZ   = $clog2(BYTES);
    localparam int CW    = TSIZE + 14;

    typedef enum logic [2:0] {
        S_IDLE, S_CALC, S_SET_VLD, S_WAIT_LAST, S_SET_BRDY, S_DONE
    } state_t;

    state_t           r_state, w_next;
    logic [TSIZE-1:0] r_remain;
    logic [ASIZE-1:0] r_addr;
    logic [ASIZE-1:0] r_awaddr;
    logic [LSIZE-1:0] r_awlen;
    logic [LSIZE:0]   r_blen;
    logic [LSIZE:0]   r_beat_cnt;
    logic             r_err;
    logic             r_req_resp;
    logic [12:0]      w_room;
    logic [CW-1:0]    w_blen_c;
    logic             w_wlast;
    logic             w_w_hs;
    logic             w_b_hs;
    logic             w_last_burst;

    // Beats left before the next 4KB page boundary
    assign w_room       = (13'd4096 - {1'b0, r_addr[11:0]}) >> ASZ;
    assign w_wlast      = (r_state == S_WAIT_LAST) && (r_beat_cnt == r_blen - (LSIZE+1)'(1));
    assign w_w_hs       = (r_state == S_WAIT_LAST) && axi_wvalid && axi_wready;
    assign w_b_hs       = (r_state == S_SET_BRDY) && axi_bvalid && (axi_bid == IDSIZE'(ID));
    assign w_last_burst = (r_remain == TSIZE'(r_blen));

    always_comb begin
        w_blen_c = CW'(r_remain);
        if (w_blen_c > CW'(MAX_BURST)) w_blen_c = CW'(MAX_BURST);
        if (w_blen_c > CW'(w_room))    w_blen_c = CW'(w_room);
    end

    always_ff @(posedge axi_aclk) begin
        if (!axi_resetn) r_state <= S_IDLE;
        else             r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        req_resp     = r_req_resp;
        req_done     = 1'b0;
        req_err      = 1'b0;
        pull_data_en = 1'b0;
        axi_awid     = IDSIZE'(ID);
        axi_awaddr   = r_awaddr;
        axi_awlen    = r_awlen;
        axi_awsize   = 3'(ASZ);
        axi_awburst  = 2'b01;
        axi_awvalid  = 1'b0;
        axi_bready   = 1'b0;
        axi_wlast    = w_wlast;
        case (r_state)
            S_IDLE:      if (write_req) w_next = (req_len == '0) ? S_DONE : S_CALC;
            S_CALC:      w_next = S_SET_VLD;
            S_SET_VLD: begin
                axi_awvalid = 1'b1;
                if (axi_awready) w_next = S_WAIT_LAST;
            end
            S_WAIT_LAST: begin
                pull_data_en = 1'b1;
                if (w_w_hs && w_wlast) w_next = S_SET_BRDY;
            end
            S_SET_BRDY: begin
                axi_bready = 1'b1;
                if (w_b_hs) w_next = ((axi_bresp != 2'b00) || w_last_burst) ? S_DONE : S_CALC;
            end
            S_DONE: begin
                req_done = 1'b1;
                req_err  = r_err;
                w_next   = S_IDLE;
            end
            default:     w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk) begin
        if (!axi_resetn) begin
            r_remain   <= '0;
            r_addr     <= '0;
            r_awaddr   <= '0;
            r_awlen    <= '0;
            r_blen     <= '0;
            r_beat_cnt <= '0;
            r_err      <= 1'b0;
            r_req_resp <= 1'b0;
        end else begin
            r_req_resp <= (r_state == S_IDLE) && write_req;
            case (r_state)
                S_IDLE: if (write_req) begin
                    r_remain <= req_len;
                    r_addr   <= req_addr;
                    r_err    <= 1'b0;
                end
                S_CALC: begin
                    r_blen   <= (LSIZE+1)'(w_blen_c);
                    r_awaddr <= r_addr;
                    r_awlen  <= LSIZE'(w_blen_c - CW'(1));
                end
                S_WAIT_LAST: if (w_w_hs) begin
                    r_beat_cnt <= w_wlast ? '0 : r_beat_cnt + (LSIZE+1)'(1);
                end
                S_SET_BRDY: if (w_b_hs) begin
                    r_remain <= r_remain - TSIZE'(r_blen);
                    r_addr   <= r_addr + (ASIZE'(r_blen) << ASZ);
                    if (axi_bresp != 2'b00) r_err <= 1'b1;
                end
                S_DONE:  r_err <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule
